tape_stream: RTL

TAPE_STREAM -- requirements
Module: tape_stream

---
 rtl/tape_stream_if.sv | 14 +
 rtl/tape_stream.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/tape_stream_if.sv
// Memory read port of tape_stream: byte-address request / one-cycle acknowledge.
// Handshake: master raises mem_rd with a stable mem_addr and holds both until
// the slave pulses mem_ready for one cycle with mem_data valid in that cycle.
interface tape_stream_if #(
  parameter int ADDR_W = 23
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_ready;
  logic [7:0]        mem_data;

  modport master (output mem_addr, output mem_rd, input mem_ready, input mem_data);
  modport slave  (input mem_addr, input mem_rd, output mem_ready, output mem_data);
endinterface

// File: rtl/tape_stream.sv
// Tape player: prefetches bytes from memory into a FIFO and serialises them MSB
// first, one sample per DIV clocks. Define TAPE_STREAM_LOOP_EN for gapless looping.
module tape_stream #(
  parameter int ADDR_W = 23,
  parameter int DEPTH  = 8,
  parameter int DIV    = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     play_toggle,
  input  logic                     rewind,
  input  logic [ADDR_W-1:0]        tape_len,
  tape_stream_if.master            mem,
  output logic                     data,
  output logic [2:0]               status,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     underrun
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int DW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic [2:0] {
    ST_NOTAPE = 3'd0,
    ST_PAUSE  = 3'd1,
    ST_PLAY   = 3'd2,
    ST_END    = 3'd3,
    ST_REWIND = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_addr, addr_inc;
  logic              wr_valid;
  logic [7:0]        wr_byte;
  logic [7:0]        fifo_mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [DW-1:0]     div_q;
  logic [7:0]        shreg;
  logic [3:0]        bit_cnt;

  logic ack, rewind_req, flush, fetching, issue;
  logic tc, need_byte, fifo_empty, pop, wr_en, end_hit;
  logic [7:0] head;

  assign status     = state_q;
  assign ack        = mem.mem_ready && mem.mem_rd;
  assign rewind_req = (rewind || (tape_len == '0)) &&
                      (state_q != ST_NOTAPE) && (state_q != ST_REWIND);
  assign flush      = rewind_req || (state_q == ST_REWIND);
  assign fetching   = (state_q == ST_PAUSE) || (state_q == ST_PLAY);
  // wr_valid is a byte already acknowledged but not yet counted in level.
  assign issue      = fetching && !flush && !mem.mem_rd && (fetch_addr < tape_len) &&
                      ((level + LW'(wr_valid)) < DEPTH_L);
  assign tc         = (state_q == ST_PLAY) && (div_q == DIV_LAST);
  assign need_byte  = tc && (bit_cnt == 4'd0);
  assign fifo_empty = (level == '0);
  assign pop        = need_byte && !fifo_empty && !flush;
  assign wr_en      = wr_valid && !flush;
  assign head       = fifo_mem[rd_ptr];

`ifdef TAPE_STREAM_LOOP_EN
  assign addr_inc = (fetch_addr == tape_len - 1'b1) ? '0 : fetch_addr + 1'b1;
  assign end_hit  = 1'b0;
`else
  logic fetched_all;
  assign addr_inc    = fetch_addr + 1'b1;
  assign fetched_all = (fetch_addr >= tape_len) && !mem.mem_rd && !wr_valid;
  assign end_hit     = need_byte && fifo_empty && fetched_all;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_NOTAPE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_NOTAPE: if (tape_len != '0) state_d = ST_PAUSE;
      ST_PAUSE: begin
        if (rewind_req)       state_d = ST_REWIND;
        else if (play_toggle) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (rewind_req)       state_d = ST_REWIND;
        else if (end_hit)     state_d = ST_END;
        else if (play_toggle) state_d = ST_PAUSE;
      end
      ST_END: if (rewind_req) state_d = ST_REWIND;
      ST_REWIND: begin
        // Leave only after any in-flight read has been acknowledged.
        if (!mem.mem_rd) state_d = (tape_len == '0) ? ST_NOTAPE : ST_PAUSE;
      end
      default: state_d = ST_NOTAPE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem.mem_rd   <= 1'b0;
      mem.mem_addr <= '0;
      fetch_addr   <= '0;
      wr_valid     <= 1'b0;
      wr_byte      <= '0;
    end else begin
      wr_valid <= ack && !flush;
      if (ack) wr_byte <= mem.mem_data;
      if (ack) begin
        mem.mem_rd <= 1'b0;
      end else if (issue) begin
        mem.mem_rd   <= 1'b1;
        mem.mem_addr <= fetch_addr;
      end
      if (flush)    fetch_addr <= '0;
      else if (ack) fetch_addr <= addr_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) fifo_mem[wr_ptr] <= wr_byte;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q    <= '0;
      data     <= 1'b0;
      shreg    <= '0;
      bit_cnt  <= '0;
      underrun <= 1'b0;
    end else if (flush) begin
      div_q    <= '0;
      bit_cnt  <= '0;
      underrun <= 1'b0;
    end else if (state_q == ST_PLAY) begin
      div_q <= tc ? '0 : div_q + 1'b1;
      if (tc) begin
        if (bit_cnt != 4'd0) begin
          data    <= shreg[7];
          shreg   <= {shreg[6:0], 1'b0};
          bit_cnt <= bit_cnt - 1'b1;
        end else if (!fifo_empty) begin
          data    <= head[7];
          shreg   <= {head[6:0], 1'b0};
          bit_cnt <= 4'd7;
        end else if (!end_hit) begin
          // Starved: hold the last sample and retry on the next period.
          underrun <= 1'b1;
        end
      end
    end
  end
endmodule
